apb_cfg_initiator: RTL and testbench
====================================

APB_CFG_INITIATOR -- requirements
Module: apb_cfg_initiator

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12: PADDR width, matching the 4KB APB slave window.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS-phase wait cycles before abort, range 1..65535.
REQ-003 SHALL have port HCLK, input, 1: sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port HRESET, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1): request handshake.
REQ-006 SHALL have ports req_addr_i (input, APB_ADDR_WIDTH), req_wdata_i (input, 32) and req_write_i (input, 1): request payload.
REQ-007 SHALL have ports rsp_valid_o (output, 1) and rsp_ready_i (input, 1): response handshake.
REQ-008 SHALL have ports rsp_rdata_o (output, 32), rsp_err_o (output, 1) and rsp_timeout_o (output, 1): response payload.
REQ-009 SHALL have APB master ports PADDR, PWDATA (32), PWRITE, PSEL and PENABLE as outputs, and PRDATA (32), PREADY and PSLVERR as inputs.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP, one outstanding transfer at a time.
REQ-011 SHALL assert req_ready_o only in IDLE; req_valid_i&&req_ready_o captures addr, wdata and write, then moves to SETUP.
REQ-012 SHALL drive PSEL=1 and PENABLE=0 in SETUP for exactly one cycle, then move to ACCESS.
REQ-013 SHALL drive PSEL=1 and PENABLE=1 in ACCESS; on PREADY=1 it captures PSLVERR into rsp_err_o, captures PRDATA into rsp_rdata_o for reads (0 for writes), and moves to RESP.
REQ-014 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP until ACCESS completes, and keep the last values in IDLE and RESP.
REQ-015 SHALL hold PSEL=0 and PENABLE=0 in IDLE and RESP.
REQ-016 SHALL hold rsp_valid_o=1 with stable payload in RESP until rsp_ready_i=1, then return to IDLE.
REQ-017 SHALL give minimum latency with PREADY=1 and rsp_ready_i=1 as: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid_o at 3, req_ready_o at 4.
REQ-018 SHALL not accept requests while rsp_valid_o is pending; there is no RESP-to-SETUP bypass.
REQ-019 SHALL ignore PREADY, PRDATA and PSLVERR outside ACCESS.

Reset
REQ-020 SHALL, while HRESET=1, put the FSM in IDLE and hold: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0, timeout count=0, req_ready_o=0.
REQ-021 SHALL drop PSEL and PENABLE immediately if reset is asserted mid-SETUP or mid-ACCESS, discard the transfer, and produce no response.
REQ-022 SHALL assert req_ready_o=1 in the first cycle after HRESET deasserts.

Configuration
REQ-023 SHALL, with macro APB_CFG_INITIATOR_TIMEOUT_EN defined, count ACCESS cycles with PREADY=0; when the count reaches TIMEOUT_CYCLES it drops PSEL/PENABLE, moves to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, and clears the count.
REQ-024 SHALL, without APB_CFG_INITIATOR_TIMEOUT_EN, wait indefinitely in ACCESS, tie rsp_timeout_o to 0, and implement no counter.
REQ-025 SHALL clear the timeout count on every entry to ACCESS; PREADY=1 in the cycle the count reaches TIMEOUT_CYCLES completes normally, with no timeout.

Structure
REQ-026 SHALL place the FSM state enum, an apb_req_t struct {addr, wdata, write} and an apb_rsp_t struct {rdata, err, timeout} in package apb_cfg_initiator_pkg.
REQ-027 SHALL place the timeout counter in sub-module apb_cfg_initiator_timeout (inputs: clear, count_en; output: expired), instantiated only under APB_CFG_INITIATOR_TIMEOUT_EN.

Verification
REQ-028 SHALL cover: write addr 0x074 data 0x000000A5, PREADY=1 -> PSEL rises at cycle 1, PENABLE at cycle 2, rsp_valid_o at cycle 3 with err=0 and rdata=0.
REQ-029 SHALL cover: read addr 0x0C4 with 3 PREADY=0 cycles and PRDATA=0x00000002 -> ACCESS lasts 4 cycles, rsp_rdata_o=0x00000002.
REQ-030 SHALL cover: write with PSLVERR=1 and PREADY=1 -> rsp_err_o=1, rsp_timeout_o=0.
REQ-031 SHALL cover: TIMEOUT_CYCLES=4 with macro defined and PREADY held 0 -> PSEL drops after 4 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1.
REQ-032 SHALL cover: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and payload stable, req_ready_o=0 throughout.
REQ-033 SHALL cover: HRESET pulsed in ACCESS -> PSEL=0 in the same cycle, no response, req_ready_o=1 after release.

Source files
------------

// File: rtl/apb_cfg_initiator_pkg.sv
// rtl/apb_cfg_initiator_pkg.sv - shared FSM state and request/response types for the APB config initiator
package apb_cfg_initiator_pkg;

    localparam int REQ_ADDR_MAX = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [31:0]             wdata;
        logic                    write;
    } apb_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_cfg_initiator_timeout.sv
// rtl/apb_cfg_initiator_timeout.sv - ACCESS wait-cycle counter, used only with APB_CFG_INITIATOR_TIMEOUT_EN
module apb_cfg_initiator_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [15:0] count;

    // expired flags the cycle whose stalled edge would make the count reach TIMEOUT_CYCLES
    assign expired = count_en && (count == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/apb_cfg_initiator.sv
// rtl/apb_cfg_initiator.sv - single-outstanding request/response to APB master bridge
// Optional ACCESS-phase abort enabled by macro APB_CFG_INITIATOR_TIMEOUT_EN.
module apb_cfg_initiator
    import apb_cfg_initiator_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    state_t   state;
    state_t   state_next;
    apb_req_t req;
    apb_rsp_t rsp;
    logic     timed_out;

`ifdef APB_CFG_INITIATOR_TIMEOUT_EN
    apb_cfg_initiator_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (HCLK),
        .rst      (HRESET),
        .clear    (state != ACCESS),
        .count_en ((state == ACCESS) && !PREADY),
        .expired  (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid_i) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (PREADY || timed_out) state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // PREADY wins over an expiry landing in the same cycle
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            req <= '0;
            rsp <= '0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                req.addr  <= REQ_ADDR_MAX'(req_addr_i);
                req.wdata <= req_wdata_i;
                req.write <= req_write_i;
            end
            if (state == ACCESS && PREADY) begin
                rsp.rdata   <= req.write ? 32'd0 : PRDATA;
                rsp.err     <= PSLVERR;
                rsp.timeout <= 1'b0;
            end else if (state == ACCESS && timed_out) begin
                rsp.rdata   <= 32'd0;
                rsp.err     <= 1'b1;
                rsp.timeout <= 1'b1;
            end
        end
    end

    assign req_ready_o   = (state == IDLE) && !HRESET;
    assign PSEL          = (state == SETUP) || (state == ACCESS);
    assign PENABLE       = (state == ACCESS);
    assign PADDR         = req.addr[APB_ADDR_WIDTH-1:0];
    assign PWDATA        = req.wdata;
    assign PWRITE        = req.write;
    assign rsp_valid_o   = (state == RESP);
    assign rsp_rdata_o   = rsp.rdata;
    assign rsp_err_o     = rsp.err;
    assign rsp_timeout_o = rsp.timeout;

endmodule

// File: tb/tb_apb_cfg_initiator.sv
// tb/tb_apb_cfg_initiator.sv - scoreboard bench for apb_cfg_initiator (timeout case under APB_CFG_INITIATOR_TIMEOUT_EN)
module tb_apb_cfg_initiator;

    localparam int AW = 12;
    localparam int TO_CYCLES = 4;

    logic          HCLK;
    logic          HRESET;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          req_write_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_cfg_initiator #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_write_i   (req_write_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PWRITE        (PWRITE),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int          wait_n   = 0;
    int          acc_cnt  = 0;
    logic [31:0] prdata_v = 32'd0;
    logic        slverr_v = 1'b0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // APB slave: junk on PREADY/PRDATA/PSLVERR outside ACCESS, scripted waits inside
    always @(negedge HCLK) begin
        if (PSEL && PENABLE) begin
            PREADY  = (acc_cnt >= wait_n);
            PRDATA  = prdata_v;
            PSLVERR = slverr_v;
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY  = 1'b1;
            PRDATA  = 32'hDEAD_BEEF;
            PSLVERR = 1'b1;
        end
    end

    // response monitor, decoupled from stimulus
    always @(negedge HCLK) begin
        if (!HRESET && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                check("rsp_timeout", 32'(rsp_timeout_o), 32'(e.to));
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #2;
    endtask

    task automatic xfer(input logic [AW-1:0] a, input logic [31:0] wd, input logic wr,
                        input int waits, input logic [31:0] rd, input logic serr, input int hold,
                        input int exp_acc, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_to);
        int   acc;
        exp_t e;
        wait_n      = waits;
        prdata_v    = rd;
        slverr_v    = serr;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_write_i = wr;
        req_valid_i = 1'b1;
        rsp_ready_i = (hold == 0);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.to    = exp_to;
        sb.push_back(e);
        check("ready_idle", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        check("setup_psel_penable", {30'd0, PSEL, PENABLE}, 32'd2);
        check("setup_paddr", 32'(PADDR), 32'(a));
        check("setup_pwdata_pwrite", PWDATA ^ 32'(PWRITE), wd ^ 32'(wr));
        check("setup_ready_low", 32'(req_ready_o), 32'd0);
        step();
        check("access_psel_penable", {30'd0, PSEL, PENABLE}, 32'd3);
        acc = 1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (!(PSEL && PENABLE)) break;
            check("access_paddr_stable", 32'(PADDR), 32'(a));
            acc++;
        end
        check("access_len", acc, exp_acc);
        check("resp_valid", 32'(rsp_valid_o), 32'd1);
        check("resp_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_rdata", rsp_rdata_o, exp_rdata);
            check("hold_flags", {30'd0, rsp_err_o, rsp_timeout_o}, {30'd0, exp_err, exp_to});
            check("hold_ready_low", 32'(req_ready_o), 32'd0);
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        check("idle_valid_low", 32'(rsp_valid_o), 32'd0);
        check("idle_ready_high", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        HRESET      = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_write_i = 1'b0;
        rsp_ready_i = 1'b1;
        PREADY      = 1'b0;
        PRDATA      = '0;
        PSLVERR     = 1'b0;
        repeat (3) step();
        check("rst_apb_ctrl", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_rsp", {28'd0, rsp_valid_o, rsp_err_o, rsp_timeout_o, req_ready_o}, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        HRESET = 1'b0;
        step();
        check("ready_after_reset", 32'(req_ready_o), 32'd1);

        // minimum-latency write; PRDATA must not leak into a write response
        xfer(12'h074, 32'h0000_00A5, 1'b1, 0, 32'h5555_AAAA, 1'b0, 0, 1, 32'd0, 1'b0, 1'b0);
        // read with three stall cycles
        xfer(12'h0C4, 32'd0, 1'b0, 3, 32'h0000_0002, 1'b0, 0, 4, 32'h0000_0002, 1'b0, 1'b0);
        // slave error on write
        xfer(12'h010, 32'h1234_5678, 1'b1, 0, 32'h0BAD_0BAD, 1'b1, 0, 1, 32'd0, 1'b1, 1'b0);
        // slave error on read still returns PRDATA
        xfer(12'h020, 32'd0, 1'b0, 1, 32'hCAFE_F00D, 1'b1, 0, 2, 32'hCAFE_F00D, 1'b1, 1'b0);
        // response back-pressure for five cycles
        xfer(12'h3FC, 32'd0, 1'b0, 0, 32'h89AB_CDEF, 1'b0, 5, 1, 32'h89AB_CDEF, 1'b0, 1'b0);
`ifdef APB_CFG_INITIATOR_TIMEOUT_EN
        xfer(12'h100, 32'd0, 1'b0, 1000, 32'h7777_7777, 1'b0, 0, TO_CYCLES, 32'd0, 1'b1, 1'b1);
        // PREADY on the final allowed cycle completes normally
        xfer(12'h104, 32'd0, 1'b0, TO_CYCLES - 1, 32'h0000_0044, 1'b0, 0, TO_CYCLES,
             32'h0000_0044, 1'b0, 1'b0);
`endif

        // reset in the middle of a stalled ACCESS: no response, bus released at once
        wait_n      = 1000;
        prdata_v    = 32'h1111_2222;
        slverr_v    = 1'b0;
        req_addr_i  = 12'h200;
        req_write_i = 1'b0;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        check("pre_rst_access", {30'd0, PSEL, PENABLE}, 32'd3);
        #1 HRESET = 1'b1;
        #1;
        check("rst_psel_same_cycle", {30'd0, PSEL, PENABLE}, 32'd0);
        check("rst_ready_low", 32'(req_ready_o), 32'd0);
        check("rst_no_rsp", 32'(rsp_valid_o), 32'd0);
        step();
        HRESET = 1'b0;
        wait_n = 0;
        step();
        check("ready_after_midrst", 32'(req_ready_o), 32'd1);
        check("midrst_paddr_cleared", 32'(PADDR), 32'd0);

        // recovery traffic at the top of the window
        xfer(12'hFFF, 32'hA5A5_5A5A, 1'b1, 2, 32'h0, 1'b0, 0, 3, 32'd0, 1'b0, 1'b0);
        xfer(12'hFFF, 32'd0, 1'b0, 0, 32'hFEED_FACE, 1'b0, 1, 1, 32'hFEED_FACE, 1'b0, 1'b0);

        repeat (3) step();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
